// File: rtl/rs232c_pkg.sv
// rs232c_pkg
//   Shared definitions for the RS232C I/O instruction dispatcher:
//   opcode constants, the dispatcher state enum, the bytes-per-word
//   derivation and small opcode-classification helpers.
package rs232c_pkg;

    localparam logic [5:0] OP_INPUTB  = 6'b111101;
    localparam logic [5:0] OP_OUTPUTB = 6'b111110;
    localparam logic [5:0] OP_INPUTW  = 6'b111011;
    localparam logic [5:0] OP_OUTPUTW = 6'b111100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_TX   = 2'd2
    } state_e;

    // Number of bytes moved by a word opcode.
    function automatic int bytes_of(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic is_input_op(input logic [5:0] op);
        return (op == OP_INPUTB) || (op == OP_INPUTW);
    endfunction

    function automatic logic is_output_op(input logic [5:0] op);
        return (op == OP_OUTPUTB) || (op == OP_OUTPUTW);
    endfunction

    function automatic logic is_word_op(input logic [5:0] op);
        return (op == OP_INPUTW) || (op == OP_OUTPUTW);
    endfunction

endpackage

// File: rtl/rs232c_io.sv
// rs232c_io
//   Dispatches byte/word RS232C I/O instructions between the decode stage
//   and the UART FIFOs. Output ops stream 1 or BYTES bytes of rt into the
//   TX FIFO; input ops collect 1 or BYTES bytes from the RX FIFO and write
//   the assembled value to the register file. One shared shift register
//   serves both directions.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   inst, inst_valid  instruction from decode (op = inst[31:26], dest = inst[20:16])
//   rt                source operand for output ops
//   busy              transfer in flight; new instructions are ignored
//   done              one-cycle pulse when an I/O instruction retires
//   push_send_data    TX FIFO push strobe, send_data is the byte
//   tx_full           TX FIFO full
//   rx_wait           RX FIFO empty; received_data valid when low
//   received_data     RX FIFO head byte
//   rx_pop            RX FIFO pop strobe
//   enable, addr, data  register-file write port
//   float             tied low
module rs232c_io
    import rs232c_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst,
    input  logic              inst_valid,
    input  logic [DATA_W-1:0] rt,
    output logic              busy,
    output logic              done,
    output logic              push_send_data,
    output logic [7:0]        send_data,
    input  logic              tx_full,
    input  logic              rx_wait,
    input  logic [7:0]        received_data,
    output logic              rx_pop,
    output logic              enable,
    output logic              float,
    output logic [4:0]        addr,
    output logic [DATA_W-1:0] data
);

    localparam int BYTES = bytes_of(DATA_W);
    localparam int CNT_W = $clog2(BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(BYTES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;       // bytes still to move
    logic [DATA_W-1:0]   shreg_q, shreg_d;   // TX shift-out / RX accumulate
    logic [4:0]          dest_q, dest_d;
    logic                word_q, word_d;
    logic                done_q, done_d;
    logic                enable_q, enable_d;
    logic [4:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [5:0]          op;
    logic [7:0]          tx_head;
    logic [CNT_W-1:0]    rx_idx;
    logic                last_byte;
    logic                unused_inst_bits;

    assign op               = inst[31:26];
    assign unused_inst_bits = ^{inst[25:21], inst[15:0]};

    // The byte on the wire is always taken from the same end of the shift
    // register; the register shifts toward that end after each push.
    assign tx_head   = BIG_ENDIAN ? shreg_q[DATA_W-1 -: 8] : shreg_q[7:0];
    // Little-endian receive places each byte by its arrival index, so a
    // single-byte INPUTB lands in bits [7:0] without a final realignment.
    assign rx_idx    = (word_q ? CNT_WORD : CNT_ONE) - cnt_q;
    assign last_byte = (cnt_q == CNT_ONE);

    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        shreg_d        = shreg_q;
        dest_d         = dest_q;
        word_d         = word_q;
        done_d         = 1'b0;
        enable_d       = 1'b0;
        addr_d         = addr_q;
        data_d         = data_q;
        push_send_data = 1'b0;
        send_data      = 8'h00;
        rx_pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inst_valid && (is_input_op(op) || is_output_op(op))) begin
                    dest_d = inst[20:16];
                    word_d = is_word_op(op);
                    cnt_d  = is_word_op(op) ? CNT_WORD : CNT_ONE;
                    if (is_output_op(op)) begin
                        state_d = ST_TX;
                        if (is_word_op(op)) begin
                            shreg_d = rt;
                        end else if (BIG_ENDIAN) begin
                            shreg_d = DATA_W'(rt[7:0]) << (DATA_W - 8);
                        end else begin
                            shreg_d = DATA_W'(rt[7:0]);
                        end
                    end else begin
                        state_d = ST_RX;
                        shreg_d = '0;
                    end
                end
            end

            ST_TX: begin
                send_data      = tx_head;
                push_send_data = ~tx_full;
                if (!tx_full) begin
                    shreg_d = BIG_ENDIAN ? (shreg_q << 8) : (shreg_q >> 8);
                    cnt_d   = cnt_q - CNT_ONE;
                    if (last_byte) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_RX: begin
                rx_pop = ~rx_wait;
                if (!rx_wait) begin
                    if (BIG_ENDIAN) begin
                        shreg_d = (shreg_q << 8) | DATA_W'(received_data);
                    end else begin
                        shreg_d = shreg_q | (DATA_W'(received_data) << {rx_idx, 3'b000});
                    end
                    cnt_d = cnt_q - CNT_ONE;
                    if (last_byte) begin
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        enable_d = 1'b1;
                        addr_d   = dest_q;
                        data_d   = shreg_d;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    // The write-back registers are reset too: addr/data must read zero
    // after reset, and a reset mid-transfer discards the partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            dest_q   <= '0;
            word_q   <= 1'b0;
            done_q   <= 1'b0;
            enable_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            dest_q   <= dest_d;
            word_q   <= word_d;
            done_q   <= done_d;
            enable_q <= enable_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign enable = enable_q;
    assign addr   = addr_q;
    assign data   = data_q;
    assign float  = 1'b0;

endmodule

// File: tb/tb_rs232c_io.sv
// tb_rs232c_io
//   Scoreboard bench for rs232c_io. Two 32-bit instances (big- and
//   little-endian) run in lockstep on identical stimulus; an 8-bit
//   instance is exercised separately. Expected TX bytes and register
//   writes are computed from the instruction semantics when an
//   instruction is issued and popped by an independent monitor.
module tb_rs232c_io;
    import rs232c_pkg::*;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } tx_exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic [31:0] rt = '0;
    logic        tx_full = 1'b0;
    logic        rx_wait = 1'b1;
    logic [7:0]  received_data = '0;

    logic        busy_be, done_be, push_be, rx_pop_be, enable_be, float_be;
    logic [7:0]  send_data_be;
    logic [4:0]  addr_be;
    logic [31:0] data_be;
    logic        busy_le, done_le, push_le, rx_pop_le, enable_le, float_le;
    logic [7:0]  send_data_le;
    logic [4:0]  addr_le;
    logic [31:0] data_le;

    logic [31:0] inst8 = '0;
    logic        valid8 = 1'b0;
    logic [7:0]  rt8 = '0;
    logic        tx_full8 = 1'b0;
    logic        rx_wait8 = 1'b1;
    logic [7:0]  rd8 = '0;
    logic        busy8, done8, push8, rx_pop8, enable8, float8;
    logic [7:0]  send_data8;
    logic [4:0]  addr8;
    logic [7:0]  data8;

    int n_checks = 0;
    int n_fail   = 0;

    tx_exp_t    tx_q_be[$];
    tx_exp_t    tx_q_le[$];
    wb_exp_t    wb_q_be[$];
    wb_exp_t    wb_q_le[$];
    logic [7:0] rx_src[$];

    int exp_done = 0;
    int done_cnt_be = 0;
    int done_cnt_le = 0;
    bit pend_be = 1'b0;
    bit pend_le = 1'b0;

    // Environment controls: random back-pressure, or forced levels.
    bit env_rand    = 1'b0;
    bit forced_full = 1'b0;
    bit forced_wait = 1'b0;

    rs232c_io #(.DATA_W(32), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid), .rt(rt),
        .busy(busy_be), .done(done_be), .push_send_data(push_be), .send_data(send_data_be),
        .tx_full(tx_full), .rx_wait(rx_wait), .received_data(received_data), .rx_pop(rx_pop_be),
        .enable(enable_be), .float(float_be), .addr(addr_be), .data(data_be)
    );

    rs232c_io #(.DATA_W(32), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid), .rt(rt),
        .busy(busy_le), .done(done_le), .push_send_data(push_le), .send_data(send_data_le),
        .tx_full(tx_full), .rx_wait(rx_wait), .received_data(received_data), .rx_pop(rx_pop_le),
        .enable(enable_le), .float(float_le), .addr(addr_le), .data(data_le)
    );

    rs232c_io #(.DATA_W(8), .BIG_ENDIAN(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .inst(inst8), .inst_valid(valid8), .rt(rt8),
        .busy(busy8), .done(done8), .push_send_data(push8), .send_data(send_data8),
        .tx_full(tx_full8), .rx_wait(rx_wait8), .received_data(rd8), .rx_pop(rx_pop8),
        .enable(enable8), .float(float8), .addr(addr8), .data(data8)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_io(input logic [5:0] op);
        return op == OP_INPUTB || op == OP_OUTPUTB || op == OP_INPUTW || op == OP_OUTPUTW;
    endfunction

    // Environment: drives FIFO flags mid-cycle and retires popped RX bytes.
    always @(negedge clk) begin
        #1;
        if (env_rand) begin
            tx_full = ($urandom_range(0, 2) == 0);
            rx_wait = (rx_src.size() == 0) || ($urandom_range(0, 2) == 0);
        end else begin
            tx_full = forced_full;
            rx_wait = (rx_src.size() == 0) || forced_wait;
        end
        received_data = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
        #1;
        if (rst_n && rx_pop_be && rx_src.size() != 0) void'(rx_src.pop_front());
    end

    // Monitor: compares every DUT output event against the scoreboard.
    always @(negedge clk) begin : monitor
        tx_exp_t t;
        wb_exp_t w;
        bit      np;
        #3;
        if (!rst_n) begin
            pend_be = 1'b0;
            pend_le = 1'b0;
        end else begin
            check("lockstep", {busy_le, push_le, rx_pop_le, enable_le, done_le},
                              {busy_be, push_be, rx_pop_be, enable_be, done_be});
            check("float_zero", {float_be, float_le, float8}, 0);
            if (push_be) check("push_while_full", tx_full, 0);
            if (rx_pop_be) check("pop_while_empty", rx_wait, 0);

            np = 1'b0;
            if (push_be) begin
                if (tx_q_be.size() == 0) check("tx_unexpected_be", push_be, 0);
                else begin
                    t = tx_q_be.pop_front();
                    check("tx_byte_be", send_data_be, t.b);
                    np = t.last;
                end
            end
            check("done_be", done_be, pend_be | enable_be);
            pend_be = np;
            if (enable_be) begin
                if (wb_q_be.size() == 0) check("wb_unexpected_be", enable_be, 0);
                else begin
                    w = wb_q_be.pop_front();
                    check("wb_addr_be", addr_be, w.addr);
                    check("wb_data_be", data_be, w.data);
                end
            end
            if (done_be) done_cnt_be++;

            np = 1'b0;
            if (push_le) begin
                if (tx_q_le.size() == 0) check("tx_unexpected_le", push_le, 0);
                else begin
                    t = tx_q_le.pop_front();
                    check("tx_byte_le", send_data_le, t.b);
                    np = t.last;
                end
            end
            check("done_le", done_le, pend_le | enable_le);
            pend_le = np;
            if (enable_le) begin
                if (wb_q_le.size() == 0) check("wb_unexpected_le", enable_le, 0);
                else begin
                    w = wb_q_le.pop_front();
                    check("wb_addr_le", addr_le, w.addr);
                    check("wb_data_le", data_le, w.data);
                end
            end
            if (done_le) done_cnt_le++;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!busy_be) return;
            @(negedge clk);
            #4;
        end
        check("idle_timeout", busy_be, 0);
    endtask

    // Issue one instruction. For input ops, src supplies the wire bytes
    // (byte i = src >> 8*i); for output ops, src is rt.
    task automatic issue(input logic [5:0] op, input logic [4:0] dest, input logic [31:0] src,
                         input bit expect_it, input bit stray);
        int          n;
        logic [31:0] vbe, vle;
        logic [7:0]  b;
        tx_exp_t     t;
        wb_exp_t     w;
        inst       = {op, 5'($urandom), dest, 16'($urandom)};
        inst_valid = 1'b1;
        rt         = src;
        if (expect_it) begin
            n = (op == OP_INPUTW || op == OP_OUTPUTW) ? 4 : 1;
            exp_done++;
            if (op == OP_OUTPUTB || op == OP_OUTPUTW) begin
                for (int i = 0; i < n; i++) begin
                    t.last = (i == n - 1);
                    t.b = 8'(src >> (8 * (n - 1 - i)));
                    tx_q_be.push_back(t);
                    t.b = 8'(src >> (8 * i));
                    tx_q_le.push_back(t);
                end
            end else begin
                vbe = 0;
                vle = 0;
                for (int i = 0; i < n; i++) begin
                    b = 8'(src >> (8 * i));
                    rx_src.push_back(b);
                    vbe = vbe * 256 + 32'(b);
                    vle = vle + (32'(b) << (8 * i));
                end
                w.addr = dest; w.data = vbe; wb_q_be.push_back(w);
                w.addr = dest; w.data = vle; wb_q_le.push_back(w);
            end
        end
        @(negedge clk);
        inst_valid = 1'b0;
        rt = $urandom;
        if (stray) begin
            inst_valid = 1'b1;
            inst = {op, 26'($urandom)};
            @(negedge clk);
            inst_valid = 1'b0;
        end
    endtask

    task automatic test_w8();
        int pushes, push_cyc, done_cyc, busy_cnt, pops, en_cyc;
        pushes = 0; push_cyc = 0; done_cyc = 0; busy_cnt = 0;
        inst8 = {OP_OUTPUTW, 5'd0, 5'd1, 16'd0};
        rt8 = 8'h5A;
        valid8 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin valid8 = 1'b0; rt8 = 8'hFF; end
            #4;
            if (push8) begin
                pushes++;
                push_cyc = c;
                check("w8_tx_byte", send_data8, 8'h5A);
            end
            if (done8) done_cyc = c;
            if (busy8) busy_cnt++;
        end
        check("w8_tx_pushes", pushes, 1);
        check("w8_tx_push_cycle", push_cyc, 1);
        check("w8_tx_done_cycle", done_cyc, 2);
        check("w8_tx_busy_cycles", busy_cnt, 1);

        pops = 0; en_cyc = 0;
        rx_wait8 = 1'b0;
        rd8 = 8'hC3;
        inst8 = {OP_INPUTW, 5'd0, 5'd9, 16'd0};
        valid8 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) valid8 = 1'b0;
            #4;
            if (rx_pop8) pops++;
            if (enable8) begin
                en_cyc = c;
                check("w8_rx_data", data8, 8'hC3);
                check("w8_rx_addr", addr8, 5'd9);
            end
        end
        rx_wait8 = 1'b1;
        check("w8_rx_pops", pops, 1);
        check("w8_rx_enable_cycle", en_cyc, 2);
    endtask

    initial begin : stimulus
        logic [5:0] op;
        int         r;

        #1;
        check("reset_be", {busy_be, done_be, push_be, rx_pop_be, enable_be, addr_be, data_be, send_data_be}, 0);
        check("reset_le", {busy_le, done_le, push_le, rx_pop_le, enable_le, addr_le, data_le, send_data_le}, 0);
        check("reset_w8", {busy8, done8, push8, rx_pop8, enable8, addr8, data8, send_data8}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #4;

        // OUTPUTB: single push of the low byte, done one cycle later.
        env_rand = 1'b0; forced_full = 1'b0; forced_wait = 1'b0;
        wait_idle();
        issue(OP_OUTPUTB, 5'd0, 32'h1234_56A5, 1'b1, 1'b0);
        #4;
        check("outb_push", push_be, 1);
        check("outb_byte", send_data_be, 8'hA5);
        check("outb_busy_c1", busy_be, 1);
        @(negedge clk);
        #4;
        check("outb_done_c2", done_be, 1);
        check("outb_busy_c2", busy_be, 0);
        check("outb_no_push_c2", push_be, 0);

        // OUTPUTW with tx_full high in cycles 2-3.
        wait_idle();
        issue(OP_OUTPUTW, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #4;
        check("outw_push_c1", push_be, 1);
        forced_full = 1'b1;
        @(negedge clk);
        #4;
        check("outw_stall_c2", push_be, 0);
        @(negedge clk);
        #4;
        check("outw_stall_c3", push_be, 0);
        forced_full = 1'b0;
        wait_idle();

        // INPUTW dest=7 with random rx_wait gaps.
        env_rand = 1'b1;
        issue(OP_INPUTW, 5'd7, 32'h4433_2211, 1'b1, 1'b0);
        wait_idle();
        env_rand = 1'b0;
        forced_wait = 1'b0;

        // INPUTB dest=3, stray INPUTB while busy must be ignored.
        wait_idle();
        issue(OP_INPUTB, 5'd3, 32'h0000_0080, 1'b1, 1'b1);
        #4;
        check("inb_enable_c2", enable_be, 1);
        check("inb_busy_c2", busy_be, 0);
        check("inb_data", data_be, 32'h0000_0080);
        check("inb_addr", addr_be, 5'd3);

        // Reset after 2 of 4 INPUTW bytes.
        wait_idle();
        rx_src.push_back(8'hA1);
        rx_src.push_back(8'hB2);
        issue(OP_INPUTW, 5'd12, 32'h0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #4;
        check("rst_mid_busy", busy_be, 1);
        check("rst_mid_pops", rx_src.size(), 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_be", {busy_be, done_be, push_be, rx_pop_be, enable_be, addr_be, data_be, send_data_be}, 0);
        check("rst_mid_le", {busy_le, done_le, push_le, rx_pop_le, enable_le, addr_le, data_le, send_data_le}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        wait_idle();
        issue(OP_INPUTW, 5'd12, $urandom, 1'b1, 1'b0);
        wait_idle();

        // Randomized mix with random back-pressure.
        env_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            wait_idle();
            r = $urandom_range(0, 5);
            case (r)
                0: op = OP_INPUTB;
                1: op = OP_OUTPUTB;
                2: op = OP_INPUTW;
                3: op = OP_OUTPUTW;
                4: op = ($urandom_range(0, 1) == 0) ? OP_OUTPUTW : OP_INPUTW;
                default: begin
                    op = 6'($urandom);
                    while (is_io(op)) op = 6'($urandom);
                end
            endcase
            issue(op, 5'($urandom), $urandom, is_io(op), is_io(op) && ($urandom_range(0, 2) == 0));
        end
        wait_idle();
        env_rand = 1'b0;

        test_w8();

        repeat (3) @(negedge clk);
        #4;
        check("tx_queue_be_empty", tx_q_be.size(), 0);
        check("tx_queue_le_empty", tx_q_le.size(), 0);
        check("wb_queue_be_empty", wb_q_be.size(), 0);
        check("wb_queue_le_empty", wb_q_le.size(), 0);
        check("rx_source_drained", rx_src.size(), 0);
        check("done_count_be", done_cnt_be, exp_done);
        check("done_count_le", done_cnt_le, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs232c_io.md
# rs232c_io

Parametrised RS232C instruction dispatcher, successor to the single-byte dispatch unit. Decodes byte and word I/O opcodes from the issuing stage, moves 1 or DATA_W/8 bytes per instruction through the UART TX/RX FIFOs with full/empty back-pressure, and writes received data to the register file. Sits between decode and the UART FIFOs. Raises `busy` while a multi-cycle transfer is in flight so the core can stall.

## Interface
- DATA_W, 32, register/data width; multiple of 8, ≥8; BYTES = DATA_W/8
- OP_INPUTB, 6'b111101, read one byte
- OP_OUTPUTB, 6'b111110, send one byte
- OP_INPUTW, 6'b111011, read BYTES bytes into one register
- OP_OUTPUTW, 6'b111100, send BYTES bytes of rt
- BIG_ENDIAN, 1, 1: first byte on the wire is the most significant byte; 0: least significant first

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- inst  in  32  instruction; op = inst[31:26], dest = inst[20:16]
- inst_valid  in  1  inst is valid this cycle
- rt  in  DATA_W  source operand for output ops
- busy  out  1  transfer in progress; new instructions ignored
- done  out  1  one-cycle pulse when an I/O instruction retires
- push_send_data  out  1  TX FIFO push strobe
- send_data  out  8  TX byte, valid with push_send_data
- tx_full  in  1  TX FIFO full
- rx_wait  in  1  RX FIFO empty; received_data valid when 0
- received_data  in  8  RX FIFO head
- rx_pop  out  1  RX FIFO pop strobe
- enable  out  1  register-file write strobe
- float  out  1  constant 0
- addr  out  5  write-back register index
- data  out  DATA_W  write-back value

## Operation
- States: IDLE, RX, TX. `busy` = (state != IDLE), registered.
- IDLE: inst_valid and op matches one of the four opcodes → latch dest, byte count (1 or BYTES), and for outputs load rt into shift register; go RX (inputs) or TX (outputs). Other opcodes or inst_valid=0: stay.
- inst_valid while busy: ignored, no side effects.
- TX: push_send_data = ~tx_full (combinational); send_data = current byte (OUTPUTB: rt[7:0]; OUTPUTW: byte order per BIG_ENDIAN). Each push advances shift register and decrements count; last push → IDLE, done=1 next cycle.
- RX: rx_pop = ~rx_wait (combinational); received_data captured at the same edge, shifted into accumulator per BIG_ENDIAN. Last capture → IDLE; at that edge register enable=1, addr=dest, data=assembled value (INPUTB zero-extended to DATA_W), done=1.
- No pushes/pops while tx_full / rx_wait are high; state holds indefinitely.
- DATA_W=8: W opcodes behave exactly as B opcodes.
- Reset (any time, including mid-transfer): state=IDLE, partial word discarded; busy, done, push_send_data, rx_pop, enable = 0; addr=0, data=0, send_data=0; float=0 always.

## Timing
- Accept at edge E0. TX/RX strobes possible from cycle after E0, one byte per cycle max.
- OUTPUTB, tx_full=0: push in cycle 1, done in cycle 2.
- INPUTB, rx_wait=0: pop in cycle 1, enable/done in cycle 2, busy low in cycle 2.
- Word ops, no back-pressure: BYTES strobe cycles, then done; each stall cycle adds one.
- enable, done: exactly one cycle wide. Next instruction may be accepted in the done cycle.

## Structure
- Package rs232c_pkg: opcode constants, state enum, BYTES derivation.
- Single module; no sub-module needed (one shared shift/accumulate register, one byte counter).

## Test plan
- OUTPUTB rt=0x1234_56A5, tx_full=0 → one push, send_data=0xA5, done one cycle later, busy 1 cycle.
- OUTPUTW rt=0xDEADBEEF, BIG_ENDIAN=1, tx_full high for cycles 2-3 → pushes DE,AD,BE,EF; no push while full; done after 4th push.
- INPUTW dest=7, RX bytes 0x11,0x22,0x33,0x44 with rx_wait=1 gaps, BIG_ENDIAN=0 → 4 pops, enable once, addr=7, data=0x44332211.
- INPUTB dest=3, byte 0x80 → data=0x0000_0080, enable 2 cycles after accept; second INPUTB issued while busy ignored (single pop).
- Reset asserted after 2 of 4 INPUTW bytes → all outputs 0 immediately, no enable; next INPUTW collects 4 fresh bytes.
- DATA_W=8 build: INPUTW/OUTPUTW transfer one byte each.
